iso_stream_sel_mux_reg: RTL and testbench
=========================================

Name: iso_stream_sel_mux_reg

Overview:
Registered, multi-lane successor of the ISO stream/blank/idle symbol selector. It picks one of three symbol sources (active, blank, idle) for LANES lanes of SYM_W-bit symbols plus per-lane control-symbol flags. Scheduler select changes are queued and applied only on a symbol boundary, so a lane never carries a mix of two sources within a transfer unit. It sits between the ISO symbol generators and the lane skew/scrambler stage.

Parameters:
LANES, 4, number of main-link lanes carried in parallel
SYM_W, 8, symbol width per lane in bits
CNT_W, 16, width of the saturating dwell counter

Ports:
clk  input  1  block clock
rst  input  1  synchronous active-high reset
active_symbols  input  LANES*SYM_W  active-video symbols, lane 0 in LSBs
active_control_sym_flag  input  LANES  per-lane control flag for active source
blank_symbols  input  LANES*SYM_W  blanking symbols
blank_control_sym_flag  input  LANES  per-lane control flag for blank source
idle_symbols  input  LANES*SYM_W  idle-pattern symbols
idle_control_sym_flag  input  LANES  per-lane control flag for idle source
sched_stream_idle_sel  input  2  requested source: 10 active, 01 blank, 00 idle, 11 illegal
sched_sel_vld  input  1  one-cycle strobe; loads sched_stream_idle_sel as the pending select
sym_boundary  input  1  high in a cycle where a source switch is permitted
err_clr  input  1  clears sel_err
mux_idle_stream_symbols  output  LANES*SYM_W  registered selected symbols
mux_control_sym_flag  output  LANES  registered selected control flags
mux_src_cur  output  2  source currently driving the outputs (registered)
sel_pending  output  1  a queued select is waiting for a boundary
sel_err  output  1  sticky: an illegal select was strobed
src_dwell_cnt  output  CNT_W  cycles since the last source change, saturating

Behaviour:
- Reset (clk edge with rst=1): mux_idle_stream_symbols=0, mux_control_sym_flag=0, mux_src_cur=00 (idle), sel_pending=0, pending select=00, sel_err=0, src_dwell_cnt=0. Reset mid-operation discards any pending select.
- Decode: 10 active, 01 blank, 00 idle. 11 maps to idle (00) when loaded, and sets sel_err.
- Queueing: sched_sel_vld=1 loads the decoded select into the pending register and sets sel_pending=1. A later strobe before the boundary overwrites it (last wins). If the decoded value equals mux_src_cur and nothing is pending, nothing is queued.
- Effective select for cycle n: sel_eff = decoded strobe value if sym_boundary and sched_sel_vld; else the pending select if sym_boundary and sel_pending; else mux_src_cur.
- Same-cycle strobe and boundary: the new value applies immediately, and sel_pending ends 0.
- At the clk edge ending cycle n:
  - mux outputs <= source[sel_eff] inputs sampled in cycle n. Latency is one cycle, all lanes switch together.
  - mux_src_cur <= sel_eff.
  - sel_pending clears if the boundary consumed the pending or strobed value.
- Dwell counter: src_dwell_cnt <= 0 when sel_eff != mux_src_cur. Otherwise it increments, saturating at 2^CNT_W-1 with no wrap.
- sel_err: set on a strobe with 11; cleared by err_clr; set wins if both occur in the same cycle.
- sym_boundary without a pending select or strobe has no effect.
- Outputs are pure registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst for 2 cycles, idle_symbols=0x1C1C1C1C, flags=4'hF. Required: outputs 0, mux_src_cur=00 during reset; one cycle after release, symbols=0x1C1C1C1C, flags=4'hF, dwell counts 0,1,2...
- Deferred switch: strobe sel=10 at cycle 5, sym_boundary at cycle 9. Required: sel_pending=1 in cycles 6-9. Active data sampled in cycle 9 appears in cycle 10 with mux_src_cur=10 and dwell=0. Idle data persists through cycle 9.
- Simultaneous strobe and boundary: sel=01 strobed with sym_boundary=1 at cycle 3. Required: blank data appears in cycle 4, sel_pending stays 0.
- Last-wins overwrite: strobe 10 at cycle 2, strobe 01 at cycle 4, boundary at cycle 6. Required: source becomes blank in cycle 7; active never appears.
- Illegal select and error: strobe 11 while active, then boundary. Required: switch to idle; sel_err=1 from the next cycle and held; err_clr together with a new 11 strobe keeps sel_err=1; err_clr alone then clears it.
- Saturation and reset mid-pending: CNT_W=4, hold one source 20 cycles → dwell stays at 15. Queue a select, then assert rst before the boundary → sel_pending=0, mux_src_cur=00, and a later boundary causes no switch.

Source files
------------

// File: rtl/iso_stream_sel_mux_reg.sv
// Registered multi-lane ISO symbol source selector (active / blank / idle).
// Scheduler select changes are queued and take effect only on a symbol boundary.
module iso_stream_sel_mux_reg #(
  parameter int LANES = 4,
  parameter int SYM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*SYM_W-1:0] active_symbols,
  input  logic [LANES-1:0]       active_control_sym_flag,
  input  logic [LANES*SYM_W-1:0] blank_symbols,
  input  logic [LANES-1:0]       blank_control_sym_flag,
  input  logic [LANES*SYM_W-1:0] idle_symbols,
  input  logic [LANES-1:0]       idle_control_sym_flag,
  input  logic [1:0]             sched_stream_idle_sel,
  input  logic                   sched_sel_vld,
  input  logic                   sym_boundary,
  input  logic                   err_clr,
  output logic [LANES*SYM_W-1:0] mux_idle_stream_symbols,
  output logic [LANES-1:0]       mux_control_sym_flag,
  output logic [1:0]             mux_src_cur,
  output logic                   sel_pending,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       src_dwell_cnt
);

  typedef enum logic [1:0] {
    SRC_IDLE   = 2'b00,
    SRC_BLANK  = 2'b01,
    SRC_ACTIVE = 2'b10
  } src_e;

  src_e                   src_cur;
  src_e                   pend_sel;
  src_e                   req_sel;
  src_e                   sel_eff;
  logic                   accept_req;
  logic                   consume;
  logic                   illegal_req;
  logic [LANES*SYM_W-1:0] next_symbols;
  logic [LANES-1:0]       next_flags;

  // The illegal code 11 falls back to idle so the link never carries garbage.
  always_comb begin
    req_sel     = SRC_IDLE;
    illegal_req = sched_sel_vld && (sched_stream_idle_sel == 2'b11);
    case (sched_stream_idle_sel)
      2'b10:   req_sel = SRC_ACTIVE;
      2'b01:   req_sel = SRC_BLANK;
      default: req_sel = SRC_IDLE;
    endcase
  end

  // A strobe on a boundary beats the older queued value; otherwise hold the source.
  always_comb begin
    consume    = sym_boundary && (sched_sel_vld || sel_pending);
    accept_req = sched_sel_vld && !((req_sel == src_cur) && !sel_pending);
    sel_eff    = src_cur;
    if (sym_boundary && sched_sel_vld) begin
      sel_eff = req_sel;
    end else if (sym_boundary && sel_pending) begin
      sel_eff = pend_sel;
    end
  end

  always_comb begin
    next_symbols = idle_symbols;
    next_flags   = idle_control_sym_flag;
    case (sel_eff)
      SRC_ACTIVE: begin
        next_symbols = active_symbols;
        next_flags   = active_control_sym_flag;
      end
      SRC_BLANK: begin
        next_symbols = blank_symbols;
        next_flags   = blank_control_sym_flag;
      end
      default: begin
        next_symbols = idle_symbols;
        next_flags   = idle_control_sym_flag;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_idle_stream_symbols <= '0;
      mux_control_sym_flag    <= '0;
      src_cur                 <= SRC_IDLE;
      pend_sel                <= SRC_IDLE;
      sel_pending             <= 1'b0;
      sel_err                 <= 1'b0;
      src_dwell_cnt           <= '0;
    end else begin
      mux_idle_stream_symbols <= next_symbols;
      mux_control_sym_flag    <= next_flags;
      src_cur                 <= sel_eff;

      if (consume) begin
        sel_pending <= 1'b0;
      end else if (accept_req) begin
        sel_pending <= 1'b1;
        pend_sel    <= req_sel;
      end

      // Set wins over clear so a same-cycle illegal strobe is never lost.
      if (illegal_req) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end

      if (sel_eff != src_cur) begin
        src_dwell_cnt <= '0;
      end else if (src_dwell_cnt != {CNT_W{1'b1}}) begin
        src_dwell_cnt <= src_dwell_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign mux_src_cur = src_cur;

endmodule

// File: tb/tb_iso_stream_sel_mux_reg.sv
// Randomized and directed bench for iso_stream_sel_mux_reg against a
// behavioural model that tracks queued selects as a last-wins request list.
module tb_iso_stream_sel_mux_reg;

  localparam int LANES = 4;
  localparam int SYM_W = 8;
  localparam int CNT_W = 4;
  localparam int DW    = LANES * SYM_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   active_symbols, blank_symbols, idle_symbols;
  logic [LANES-1:0] active_control_sym_flag, blank_control_sym_flag, idle_control_sym_flag;
  logic [1:0]      sched_stream_idle_sel;
  logic            sched_sel_vld, sym_boundary, err_clr;
  logic [DW-1:0]   mux_idle_stream_symbols;
  logic [LANES-1:0] mux_control_sym_flag;
  logic [1:0]      mux_src_cur;
  logic            sel_pending, sel_err;
  logic [CNT_W-1:0] src_dwell_cnt;

  int nCompared = 0;
  int nMismatch = 0;
  bit randData  = 1'b1;

  // Reference model state
  int              mCur;
  int              pendQ[$];
  int              mDwell;
  bit              mErr;
  logic [DW-1:0]   mSym;
  logic [LANES-1:0] mFlag;

  iso_stream_sel_mux_reg #(.LANES(LANES), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .active_symbols(active_symbols), .active_control_sym_flag(active_control_sym_flag),
    .blank_symbols(blank_symbols), .blank_control_sym_flag(blank_control_sym_flag),
    .idle_symbols(idle_symbols), .idle_control_sym_flag(idle_control_sym_flag),
    .sched_stream_idle_sel(sched_stream_idle_sel), .sched_sel_vld(sched_sel_vld),
    .sym_boundary(sym_boundary), .err_clr(err_clr),
    .mux_idle_stream_symbols(mux_idle_stream_symbols),
    .mux_control_sym_flag(mux_control_sym_flag),
    .mux_src_cur(mux_src_cur), .sel_pending(sel_pending),
    .sel_err(sel_err), .src_dwell_cnt(src_dwell_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model one clock edge from the inputs presented during the cycle.
  task automatic modelEdge();
    int req, nxt;
    if (rst) begin
      mCur = 0; pendQ.delete(); mDwell = 0; mErr = 1'b0; mSym = '0; mFlag = '0;
      return;
    end
    req = (sched_stream_idle_sel == 2'b11) ? 0 : int'(sched_stream_idle_sel);
    if (sym_boundary && sched_sel_vld)          nxt = req;
    else if (sym_boundary && pendQ.size() > 0)  nxt = pendQ[$];
    else                                        nxt = mCur;
    if (sym_boundary && (sched_sel_vld || pendQ.size() > 0)) pendQ.delete();
    else if (sched_sel_vld && !(req == mCur && pendQ.size() == 0)) pendQ.push_back(req);
    mDwell = (nxt != mCur) ? 0 : ((mDwell + 1 > 2**CNT_W - 1) ? 2**CNT_W - 1 : mDwell + 1);
    if (sched_sel_vld && sched_stream_idle_sel == 2'b11) mErr = 1'b1;
    else if (err_clr) mErr = 1'b0;
    case (nxt)
      2:       begin mSym = active_symbols; mFlag = active_control_sym_flag; end
      1:       begin mSym = blank_symbols;  mFlag = blank_control_sym_flag;  end
      default: begin mSym = idle_symbols;   mFlag = idle_control_sym_flag;   end
    endcase
    mCur = nxt;
  endtask

  // Drive one cycle of control, advance the clock, then compare all outputs.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] s, input bit b, input bit c);
    rst = r; sched_sel_vld = v; sched_stream_idle_sel = s; sym_boundary = b; err_clr = c;
    if (randData) begin
      active_symbols = $urandom; blank_symbols = $urandom; idle_symbols = $urandom;
      active_control_sym_flag = 4'($urandom);
      blank_control_sym_flag  = 4'($urandom);
      idle_control_sym_flag   = 4'($urandom);
    end
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("symbols", mux_idle_stream_symbols, mSym);
    checkOutput("flags",   32'(mux_control_sym_flag), 32'(mFlag));
    checkOutput("src_cur", 32'(mux_src_cur), 32'(mCur));
    checkOutput("pending", 32'(sel_pending), 32'(pendQ.size() != 0));
    checkOutput("sel_err", 32'(sel_err), 32'(mErr));
    checkOutput("dwell",   32'(src_dwell_cnt), 32'(mDwell));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sched_sel_vld = 1'b0; sched_stream_idle_sel = 2'b00; sym_boundary = 1'b0; err_clr = 1'b0;
    active_symbols = '0; blank_symbols = '0; idle_symbols = '0;
    active_control_sym_flag = '0; blank_control_sym_flag = '0; idle_control_sym_flag = '0;
    mCur = 0; mDwell = 0; mErr = 1'b0; mSym = '0; mFlag = '0;
    #1;

    // Reset then idle with a fixed idle pattern
    randData = 1'b0;
    idle_symbols = 32'h1C1C1C1C; idle_control_sym_flag = 4'hF;
    active_symbols = 32'hAAAA5555; blank_symbols = 32'hB0B1B2B3;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("reset_sym", mux_idle_stream_symbols, 32'h0);
    checkOutput("reset_src", 32'(mux_src_cur), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("idle_sym_const", mux_idle_stream_symbols, 32'h1C1C1C1C);
    checkOutput("idle_flag_const", 32'(mux_control_sym_flag), 32'hF);
    idleCycles(2);

    // Deferred switch: strobe active, boundary four cycles later
    randData = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("deferred_pend", 32'(sel_pending), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("deferred_src", 32'(mux_src_cur), 32'h2);
    checkOutput("deferred_dwell", 32'(src_dwell_cnt), 32'h0);

    // Simultaneous strobe and boundary to blank
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    checkOutput("simul_src", 32'(mux_src_cur), 32'h1);
    checkOutput("simul_pend", 32'(sel_pending), 32'h0);

    // Last-wins overwrite: active then idle, then boundary
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("lastwins_src", 32'(mux_src_cur), 32'h0);

    // Illegal select while active, with sticky error handling
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("illegal_err", 32'(sel_err), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("illegal_src", 32'(mux_src_cur), 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("err_set_wins", 32'(sel_err), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("err_cleared", 32'(sel_err), 32'h0);

    // Dwell saturation over 20 cycles on one source
    idleCycles(20);
    checkOutput("dwell_sat", 32'(src_dwell_cnt), 32'hF);

    // Reset while a select is queued discards it
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("rst_pend", 32'(sel_pending), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rst_noswitch", 32'(mux_src_cur), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 99) < 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
